soc_system_sysid_check: RTL and testbench
=========================================

SOC_SYSTEM_SYSID_CHECK -- requirements
Module: soc_system_sysid_check

Interface
REQ-001 The block SHALL have parameter EXPECTED_ID, default 32'h0000_0000: the system ID value that counts as a pass.
REQ-002 The block SHALL have parameter START_DELAY, default 16: cycles from reset release to the automatic first check.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles per read transaction, measured from read assertion to readdatavalid.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3: full-sequence retries allowed after the first attempt.
REQ-005 The block SHALL have port clock, input, 1: single clock domain.
REQ-006 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1: single-cycle pulse that requests a re-check.
REQ-008 The block SHALL have port avm_address, output, 1: word address; 0 = system ID, 1 = timestamp.
REQ-009 The block SHALL have port avm_read, output, 1: Avalon-MM read request.
REQ-010 The block SHALL have port avm_waitrequest, input, 1: interconnect stall.
REQ-011 The block SHALL have port avm_readdata, input, 32: read data.
REQ-012 The block SHALL have port avm_readdatavalid, input, 1: read data qualifier.
REQ-013 The block SHALL have outputs sys_id and sys_timestamp, 32 each: captured values.
REQ-014 The block SHALL have outputs busy, done, id_ok and error, 1 each: status flags.
REQ-015 The block SHALL have output retry_count, 2: count of retries used.

Function
REQ-016 The block SHALL implement the states INIT_WAIT, ID_REQ, ID_RSP, TS_REQ, TS_RSP, CHECK, DONE and FAIL.
REQ-017 INIT_WAIT SHALL count START_DELAY cycles and then enter ID_REQ.
REQ-018 In a REQ state, avm_read SHALL be 1 and avm_address SHALL be held stable (0 in ID_REQ, 1 in TS_REQ) while avm_waitrequest=1.
REQ-019 A read SHALL be accepted on the first cycle with avm_read=1 and avm_waitrequest=0; avm_read SHALL be 0 on the next cycle, and the FSM SHALL enter the matching RSP state.
REQ-020 Exactly one read SHALL be outstanding at any time.
REQ-021 In an RSP state, the first cycle with avm_readdatavalid=1 SHALL capture avm_readdata into sys_id (ID_RSP) or sys_timestamp (TS_RSP).
REQ-022 After capture, ID_RSP SHALL advance to TS_REQ and TS_RSP SHALL advance to CHECK.
REQ-023 Zero-wait responses SHALL be supported: a response one cycle after acceptance costs no extra cycle.
REQ-024 avm_readdatavalid SHALL be ignored outside the RSP states.
REQ-025 A timeout counter SHALL clear on entry to each REQ state and increment every cycle in REQ/RSP.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES, the transaction SHALL abort: avm_read=0 and a retry is taken.
REQ-027 CHECK SHALL last one cycle: if sys_id==EXPECTED_ID, go to DONE; otherwise take a retry.
REQ-028 Retry: if retry_count<MAX_RETRIES, increment retry_count (saturating at 3) and return to ID_REQ; otherwise go to FAIL.
REQ-029 Flags: busy=1 in all states except DONE and FAIL.
REQ-030 Flags: done=1 in DONE and FAIL.
REQ-031 Flags: id_ok=1 only in DONE.
REQ-032 Flags: error=1 only in FAIL.
REQ-033 start in DONE or FAIL SHALL clear retry_count, id_ok and error and enter ID_REQ on the next cycle, with no START_DELAY.
REQ-034 start while busy=1 SHALL be ignored.
REQ-035 sys_id and sys_timestamp SHALL hold their last captured values until overwritten.

Reset
REQ-036 While reset=1 at a clock edge, the block SHALL set: state=INIT_WAIT, avm_read=0, avm_address=0, sys_id=0, sys_timestamp=0, busy=1, done=0, id_ok=0, error=0, retry_count=0, all counters=0.
REQ-037 A reset during an outstanding read SHALL drop avm_read at that edge, and any later readdatavalid for that read SHALL be ignored.
REQ-038 The first read after reset release SHALL begin exactly START_DELAY cycles after reset deasserts.

Verification
REQ-039 Nominal, zero-wait slave returning ID 0 and timestamp 32'h594D_8E9B -> sys_timestamp=32'h594D8E9B, id_ok=1, done=1, retry_count=0; ID_REQ entered at cycle 16 after reset.
REQ-040 waitrequest held high 5 cycles on each read -> avm_read and avm_address stable throughout; same pass result.
REQ-041 Slave returns ID 32'h1234_5678 always, MAX_RETRIES=3 -> 4 full read pairs, then error=1, id_ok=0, retry_count=3.
REQ-042 No readdatavalid for the first ID read, TIMEOUT_CYCLES=255 -> avm_read dropped after 255 cycles, retry_count=1, second attempt passes.
REQ-043 Reset asserted mid-TS_RSP, then stray readdatavalid with 32'hDEAD_BEEF -> sys_timestamp stays 0, outputs at reset values.
REQ-044 start pulse in DONE, plus a start pulse while busy -> re-check begins next cycle; busy-time pulse has no effect.

Source files
------------

// File: rtl/soc_system_sysid_check.sv
// Boot-time system ID checker: reads the sysid word and the timestamp over Avalon-MM,
// compares the ID against EXPECTED_ID, and retries the full sequence on timeout or mismatch.
module soc_system_sysid_check #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter int unsigned START_DELAY    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic [31:0] sys_id,
   output logic [31:0] sys_timestamp,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        error,
   output logic [1:0]  retry_count
);

   typedef enum logic [2:0] {
      INIT_WAIT, ID_REQ, ID_RSP, TS_REQ, TS_RSP, CHECK, DONE, FAIL
   } state_t;

   state_t      state_q, state_d;
   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic [31:0] dly_q, dly_d;
   logic [31:0] tmo_q, tmo_d;
   logic [1:0]  retry_q, retry_d;
   logic        busy_q, done_q, ok_q, err_q;
   logic        tmo_hit, take_retry;

   // Counter value after this cycle would reach the limit.
   assign tmo_hit = (tmo_q + 32'd1) >= TIMEOUT_CYCLES;

   always_comb begin
      state_d    = state_q;
      read_d     = 1'b0;
      addr_d     = addr_q;
      id_d       = id_q;
      ts_d       = ts_q;
      dly_d      = dly_q;
      tmo_d      = tmo_q;
      retry_d    = retry_q;
      take_retry = 1'b0;
      case (state_q)
         INIT_WAIT: begin
            if ((dly_q + 32'd1) >= START_DELAY) begin
               state_d = ID_REQ;
               read_d  = 1'b1;
               addr_d  = 1'b0;
               tmo_d   = '0;
            end else begin
               dly_d = dly_q + 32'd1;
            end
         end
         ID_REQ, TS_REQ: begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_hit) begin
               take_retry = 1'b1;
            end else if (!avm_waitrequest) begin
               state_d = (state_q == ID_REQ) ? ID_RSP : TS_RSP;
            end else begin
               read_d = 1'b1;
            end
         end
         ID_RSP, TS_RSP: begin
            tmo_d = tmo_q + 32'd1;
            if (avm_readdatavalid) begin
               if (state_q == ID_RSP) begin
                  id_d    = avm_readdata;
                  state_d = TS_REQ;
                  read_d  = 1'b1;
                  addr_d  = 1'b1;
                  tmo_d   = '0;
               end else begin
                  ts_d    = avm_readdata;
                  state_d = CHECK;
               end
            end else if (tmo_hit) begin
               take_retry = 1'b1;
            end
         end
         CHECK: begin
            if (id_q == EXPECTED_ID) state_d = DONE;
            else                     take_retry = 1'b1;
         end
         DONE, FAIL: begin
            if (start) begin
               retry_d = '0;
               state_d = ID_REQ;
               read_d  = 1'b1;
               addr_d  = 1'b0;
               tmo_d   = '0;
            end
         end
         default: state_d = INIT_WAIT;
      endcase

      if (take_retry) begin
         if (32'(retry_q) < MAX_RETRIES) begin
            retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
            state_d = ID_REQ;
            read_d  = 1'b1;
            addr_d  = 1'b0;
            tmo_d   = '0;
         end else begin
            state_d = FAIL;
            read_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= INIT_WAIT;
         read_q  <= 1'b0;
         addr_q  <= 1'b0;
         id_q    <= '0;
         ts_q    <= '0;
         dly_q   <= '0;
         tmo_q   <= '0;
         retry_q <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         read_q  <= read_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         ts_q    <= ts_d;
         dly_q   <= dly_d;
         tmo_q   <= tmo_d;
         retry_q <= retry_d;
         busy_q  <= !(state_d == DONE || state_d == FAIL);
         done_q  <= (state_d == DONE || state_d == FAIL);
         ok_q    <= (state_d == DONE);
         err_q   <= (state_d == FAIL);
      end
   end

   assign avm_read      = read_q;
   assign avm_address   = addr_q;
   assign sys_id        = id_q;
   assign sys_timestamp = ts_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign id_ok         = ok_q;
   assign error         = err_q;
   assign retry_count   = retry_q;

endmodule

// File: tb/tb_soc_system_sysid_check.sv
// Directed bench for soc_system_sysid_check: table of full check runs against a
// behavioural Avalon slave, then hand sequences for start, timeout and reset corners.
module tb_soc_system_sysid_check;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        avm_address, avm_read;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = '0;
   logic        avm_readdatavalid = 1'b0;
   logic [31:0] sys_id, sys_timestamp;
   logic        busy, done, id_ok, error;
   logic [1:0]  retry_count;

   soc_system_sysid_check dut (
      .clock(clock), .reset(reset), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .sys_id(sys_id), .sys_timestamp(sys_timestamp),
      .busy(busy), .done(done), .id_ok(id_ok), .error(error),
      .retry_count(retry_count)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // slave configuration and observation
   logic [31:0] id_cfg = '0, ts_cfg = '0;
   int  wait_cfg = 0, drop_id = 0;
   bit  drop_ts = 0, stray = 0, chk_stable = 0;
   int  n_id_acc = 0, n_ts_acc = 0, n_rise = 0;
   int  rise_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic slave_loop();
      bit acc_pend = 0, acc_addr = 0, prev_read = 0, prev_addr = 0, prev_wr = 0;
      int wl = 0;
      forever begin
         @(negedge clock);
         avm_readdatavalid = 1'b0;
         if (chk_stable && prev_read && prev_wr) begin
            check("read_held", 32'(avm_read), 32'd1);
            check("addr_stable", 32'(avm_address), 32'(prev_addr));
         end
         if (reset) begin
            acc_pend = 0;
            wl = wait_cfg;
            avm_waitrequest = 1'b0;
         end else begin
            if (acc_pend) begin
               acc_pend = 0;
               if (!acc_addr) begin
                  if (drop_id > 0) drop_id--;
                  else begin avm_readdatavalid = 1'b1; avm_readdata = id_cfg; end
               end else if (!drop_ts) begin
                  avm_readdatavalid = 1'b1; avm_readdata = ts_cfg;
               end
            end
            if (avm_read) begin
               if (!prev_read) begin n_rise++; rise_q.push_back(cyc); end
               if (wl > 0) begin
                  avm_waitrequest = 1'b1; wl--;
               end else begin
                  avm_waitrequest = 1'b0; acc_pend = 1; acc_addr = avm_address; wl = wait_cfg;
                  if (avm_address) n_ts_acc++; else n_id_acc++;
               end
            end else begin
               avm_waitrequest = 1'b0;
            end
         end
         if (stray) begin avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF; end
         prev_read = avm_read; prev_addr = avm_address; prev_wr = avm_waitrequest;
      end
   endtask

   task automatic wait_done(input int lim, input string name);
      int n = 0;
      while (done !== 1'b1 && n < lim) begin @(negedge clock); n++; end
      if (done !== 1'b1) check({name, "_done_timeout"}, 32'(done), 32'd1);
   endtask

   task automatic pulse_start();
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
   endtask

   typedef struct {
      logic [31:0] id;
      logic [31:0] ts;
      int          wt;
      bit          ok;
      bit          err;
      logic [1:0]  rc;
      int          nid;
   } vec_t;
   vec_t vecs[4];

   initial begin
      int r0, base_id, base_rise;
      vecs[0] = '{32'h0000_0000, 32'h594D_8E9B, 0, 1'b1, 1'b0, 2'd0, 1};
      vecs[1] = '{32'h0000_0000, 32'h594D_8E9B, 5, 1'b1, 1'b0, 2'd0, 1};
      vecs[2] = '{32'h0000_0000, 32'hA5A5_0001, 2, 1'b1, 1'b0, 2'd0, 1};
      vecs[3] = '{32'h1234_5678, 32'h0000_1111, 1, 1'b0, 1'b1, 2'd3, 4};

      fork slave_loop(); join_none

      repeat (3) @(negedge clock);
      check("rst_read",  32'(avm_read), 32'd0);
      check("rst_addr",  32'(avm_address), 32'd0);
      check("rst_busy",  32'(busy), 32'd1);
      check("rst_done",  32'(done), 32'd0);
      check("rst_idok",  32'(id_ok), 32'd0);
      check("rst_err",   32'(error), 32'd0);
      check("rst_retry", 32'(retry_count), 32'd0);
      check("rst_sysid", sys_id, 32'd0);
      check("rst_ts",    sys_timestamp, 32'd0);

      for (int v = 0; v < 4; v++) begin
         @(negedge clock);
         reset = 1'b1;
         id_cfg = vecs[v].id; ts_cfg = vecs[v].ts; wait_cfg = vecs[v].wt;
         chk_stable = (vecs[v].wt > 0);
         n_id_acc = 0; n_ts_acc = 0; n_rise = 0; rise_q.delete();
         repeat (2) @(negedge clock);
         reset = 1'b0;
         r0 = cyc;
         repeat (15) @(negedge clock);
         check($sformatf("v%0d_no_early_read", v), 32'(avm_read), 32'd0);
         wait_done(2000, $sformatf("v%0d", v));
         check($sformatf("v%0d_first_read_cyc", v), 32'(rise_q.size() > 0 ? rise_q[0] : -1), 32'(r0 + 16));
         check($sformatf("v%0d_sysid", v), sys_id, vecs[v].id);
         check($sformatf("v%0d_ts", v), sys_timestamp, vecs[v].ts);
         check($sformatf("v%0d_idok", v), 32'(id_ok), 32'(vecs[v].ok));
         check($sformatf("v%0d_err", v), 32'(error), 32'(vecs[v].err));
         check($sformatf("v%0d_retry", v), 32'(retry_count), 32'(vecs[v].rc));
         check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
         check($sformatf("v%0d_id_reads", v), 32'(n_id_acc), 32'(vecs[v].nid));
         check($sformatf("v%0d_ts_reads", v), 32'(n_ts_acc), 32'(vecs[v].nid));
      end
      chk_stable = 0;

      // start from FAIL clears status and re-checks immediately
      id_cfg = 32'h0000_0000; ts_cfg = 32'h0BAD_F00D; wait_cfg = 0;
      pulse_start();
      check("fail_start_read",  32'(avm_read), 32'd1);
      check("fail_start_busy",  32'(busy), 32'd1);
      check("fail_start_err",   32'(error), 32'd0);
      check("fail_start_retry", 32'(retry_count), 32'd0);
      wait_done(200, "restart");
      check("restart_idok", 32'(id_ok), 32'd1);
      check("restart_ts",   sys_timestamp, 32'h0BAD_F00D);

      // start while busy must not restart or add a sequence
      base_id = n_id_acc; base_rise = n_rise;
      pulse_start();
      check("done_start_read", 32'(avm_read), 32'd1);
      repeat (2) @(negedge clock);
      start = 1'b1; @(negedge clock); start = 1'b0;
      wait_done(200, "busy_start");
      repeat (20) @(negedge clock);
      check("busy_start_id_reads", 32'(n_id_acc - base_id), 32'd1);
      check("busy_start_rises", 32'(n_rise - base_rise), 32'd2);
      check("busy_start_done", 32'(done), 32'd1);

      // first ID read never answered: retry after TIMEOUT_CYCLES
      drop_id = 1; rise_q.delete(); base_id = n_id_acc;
      pulse_start();
      wait_done(1000, "timeout");
      check("tmo_rise_gap", 32'(rise_q.size() > 1 ? rise_q[1] - rise_q[0] : -1), 32'd255);
      check("tmo_retry", 32'(retry_count), 32'd1);
      check("tmo_idok",  32'(id_ok), 32'd1);
      check("tmo_id_reads", 32'(n_id_acc - base_id), 32'd2);

      // reset while the timestamp read is outstanding, then a stray response
      drop_ts = 1; base_id = n_ts_acc;
      pulse_start();
      for (int n = 0; n < 50 && n_ts_acc == base_id; n++) @(negedge clock);
      check("ts_read_seen", 32'(n_ts_acc - base_id), 32'd1);
      @(negedge clock);
      reset = 1'b1; stray = 1;
      @(negedge clock);
      check("rst_mid_read", 32'(avm_read), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      stray = 0;
      @(negedge clock);
      check("stray_ts",    sys_timestamp, 32'd0);
      check("stray_sysid", sys_id, 32'd0);
      check("stray_busy",  32'(busy), 32'd1);
      check("stray_done",  32'(done), 32'd0);
      check("stray_idok",  32'(id_ok), 32'd0);
      check("stray_retry", 32'(retry_count), 32'd0);
      drop_ts = 0;
      wait_done(200, "after_reset");
      check("after_reset_idok", 32'(id_ok), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
